ifm_pingpong_arbiter: RTL and testbench

//  Double-buffered (ping-pong) IFM memory arbiter between two conv-layer control units.
//  The producer CU writes one bank while the consumer CU reads the other bank.

---
 rtl/ifm_pingpong_arbiter.sv | 142 ++++++++++++++
 tb/tb_ifm_pingpong_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ifm_pingpong_arbiter.sv
// Ping-pong IFM bank arbiter: producer CU fills one bank while the consumer CU
// drains the other, with start/end level handshakes steering bank ownership.
module ifm_pingpong_arbiter #(
  parameter int IFM_SIZE     = 14,
  parameter int ADDRESS_SIZE = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_from_previous,
  output logic                    end_to_previous,
  output logic                    start_to_next,
  input  logic                    end_from_next,
  input  logic                    wr_en_in,
  input  logic [ADDRESS_SIZE-1:0] wr_addr_in,
  input  logic                    rd_en_in,
  input  logic [ADDRESS_SIZE-1:0] rd_addr_in,
  output logic [1:0]              bank_en,
  output logic [1:0]              bank_we,
  output logic [ADDRESS_SIZE-1:0] bank0_addr,
  output logic [ADDRESS_SIZE-1:0] bank1_addr,
  output logic                    rd_bank_sel,
  output logic [1:0]              fill_count,
  output logic                    overflow_err
);

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e bank_q [2];
  bank_state_e bank_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        busy_q, busy_d;
  logic        seen_low_q, seen_low_d;
  logic        start_q, start_d;
  logic        ovf_q, ovf_d;
  logic        launch;
  logic        wr_ready;

  logic [ADDRESS_SIZE-1:0] addr [2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bank_q[0]  <= FILLING;
      bank_q[1]  <= FREE;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      busy_q     <= 1'b0;
      seen_low_q <= 1'b0;
      start_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      seen_low_q <= seen_low_d;
      start_q    <= start_d;
      ovf_q      <= ovf_d;
    end
  end

  assign wr_ready = (bank_q[wr_ptr_q] == FILLING);
  assign launch   = (bank_q[rd_ptr_q] == FULL) && end_from_next && !busy_q;

  always_comb begin
    bank_d[0]  = bank_q[0];
    bank_d[1]  = bank_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    busy_d     = busy_q;
    seen_low_d = seen_low_q;
    start_d    = 1'b0;
    ovf_d      = ovf_q;

    if (launch) begin
      bank_d[rd_ptr_q] = DRAINING;
      busy_d           = 1'b1;
      seen_low_d       = 1'b0;
      start_d          = 1'b1;
    end

    if (busy_q) begin
      if (!end_from_next) begin
        seen_low_d = 1'b1;
      end else if (seen_low_q) begin
        bank_d[rd_ptr_q] = FREE;
        rd_ptr_d         = ~rd_ptr_q;
        busy_d           = 1'b0;
      end
    end

    if (start_from_previous) begin
      if (wr_ready) begin
        bank_d[wr_ptr_q] = FULL;
        wr_ptr_d         = ~wr_ptr_q;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Resolved after release and completion so a bank freed this cycle is
    // claimed for writing on the same edge.
    if (bank_d[wr_ptr_d] == FREE) begin
      bank_d[wr_ptr_d] = FILLING;
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < 2; b++) begin
      bank_en[b] = 1'b0;
      bank_we[b] = 1'b0;
      addr[b]    = '0;
      case (bank_q[b])
        FILLING: begin
          bank_en[b] = wr_en_in;
          bank_we[b] = wr_en_in;
          addr[b]    = wr_addr_in;
        end
        DRAINING: begin
          bank_en[b] = rd_en_in;
          addr[b]    = rd_addr_in;
        end
        default: ;
      endcase
    end
  end

  assign bank0_addr      = addr[0];
  assign bank1_addr      = addr[1];
  assign end_to_previous = wr_ready;
  assign start_to_next   = start_q;
  assign rd_bank_sel     = rd_ptr_q;
  assign overflow_err    = ovf_q;
  assign fill_count      = {1'b0, bank_q[0][1]} + {1'b0, bank_q[1][1]};

endmodule

// File: tb/tb_ifm_pingpong_arbiter.sv
// Scoreboard bench for ifm_pingpong_arbiter: directed stimulus pushes hand-computed
// expectations; a negedge monitor pops and compares them and every start_to_next pulse.
module tb_ifm_pingpong_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_from_previous;
  logic          end_to_previous;
  logic          start_to_next;
  logic          end_from_next;
  logic          wr_en_in;
  logic [AW-1:0] wr_addr_in;
  logic          rd_en_in;
  logic [AW-1:0] rd_addr_in;
  logic [1:0]    bank_en;
  logic [1:0]    bank_we;
  logic [AW-1:0] bank0_addr;
  logic [AW-1:0] bank1_addr;
  logic          rd_bank_sel;
  logic [1:0]    fill_count;
  logic          overflow_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [25:0] exp;
  } snap_t;

  snap_t snap_q [$];
  logic  launch_q [$];

  ifm_pingpong_arbiter #(.IFM_SIZE(14), .ADDRESS_SIZE(AW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_from_previous (start_from_previous),
    .end_to_previous     (end_to_previous),
    .start_to_next       (start_to_next),
    .end_from_next       (end_from_next),
    .wr_en_in            (wr_en_in),
    .wr_addr_in          (wr_addr_in),
    .rd_en_in            (rd_en_in),
    .rd_addr_in          (rd_addr_in),
    .bank_en             (bank_en),
    .bank_we             (bank_we),
    .bank0_addr          (bank0_addr),
    .bank1_addr          (bank1_addr),
    .rd_bank_sel         (rd_bank_sel),
    .fill_count          (fill_count),
    .overflow_err        (overflow_err)
  );

  always #5 clk = ~clk;

  // Snapshot layout: {start, etp, fill[1:0], ovf, rsel, en[1:0], we[1:0], a0[7:0], a1[7:0]}
  always @(negedge clk) begin
    logic [25:0] got;
    snap_t       s;
    logic        bank;
    got = {start_to_next, end_to_previous, fill_count, overflow_err, rd_bank_sel,
           bank_en, bank_we, bank0_addr, bank1_addr};
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      checks++;
      if (got !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
    end
    if (start_to_next === 1'b1) begin
      checks++;
      if (launch_q.size() == 0) begin
        errors++;
        $display("FAIL launch_unexpected: got pulse on bank %0d expected no pulse", rd_bank_sel);
      end else begin
        bank = launch_q.pop_front();
        if (rd_bank_sel !== bank) begin
          errors++;
          $display("FAIL launch_bank: got %0d expected %0d", rd_bank_sel, bank);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sfp, input logic efn, input logic wen,
                       input logic [AW-1:0] waddr, input logic ren, input logic [AW-1:0] raddr);
    start_from_previous = sfp;
    end_from_next       = efn;
    wr_en_in            = wen;
    wr_addr_in          = waddr;
    rd_en_in            = ren;
    rd_addr_in          = raddr;
  endtask

  task automatic expect_snap(input string name, input logic st, input logic etp,
                             input logic [1:0] fc, input logic ovf, input logic rs,
                             input logic [1:0] en, input logic [1:0] we,
                             input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    snap_t s;
    s.name = name;
    s.exp  = {st, etp, fc, ovf, rs, en, we, a0, a1};
    snap_q.push_back(s);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 1, 0, 0, 0, 0);
    expect_snap("reset_state", 0, 1, 2'd0, 0, 0, 2'b00, 2'b00, 8'd0, 8'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // T1: fill bank0 and hand it over
    for (int i = 0; i < 196; i++) begin
      drive(0, 1, 1, AW'(i), 0, 0);
      if (i == 0 || i == 195)
        expect_snap("t1_fill", 0, 1, 2'd0, 0, 0, 2'b01, 2'b01, AW'(i), 8'd0);
      tick();
    end
    drive(1, 1, 0, 0, 0, 0);
    expect_snap("t1_done", 0, 1, 2'd0, 0, 0, 2'b00, 2'b00, 8'd0, 8'd0);
    tick();
    drive(0, 1, 0, 0, 0, 0);
    launch_q.push_back(1'b0);
    expect_snap("t1_full", 0, 1, 2'd1, 0, 0, 2'b00, 2'b00, 8'd0, 8'd0);
    tick();
    drive(0, 1, 1, 8'd7, 0, 8'd3);
    expect_snap("t1_launch", 1, 1, 2'd1, 0, 0, 2'b10, 2'b10, 8'd3, 8'd7);
    tick();

    // T2: fill bank1 while consumer busy, then overflow
    drive(1, 0, 0, 0, 0, 0);
    expect_snap("t2_fill1", 0, 1, 2'd1, 0, 0, 2'b00, 2'b00, 8'd0, 8'd0);
    tick();
    drive(1, 0, 1, 8'd9, 1, 8'd5);
    expect_snap("t2_full2", 0, 0, 2'd2, 0, 0, 2'b01, 2'b00, 8'd5, 8'd0);
    tick();
    drive(0, 0, 1, 8'd9, 1, 8'd5);
    expect_snap("t2_ovf", 0, 0, 2'd2, 1, 0, 2'b01, 2'b00, 8'd5, 8'd0);
    tick();

    // T3: long consumer busy period, then release
    repeat (200) tick();
    expect_snap("t3_held", 0, 0, 2'd2, 1, 0, 2'b01, 2'b00, 8'd5, 8'd0);
    tick();
    drive(0, 1, 1, 8'd11, 1, 8'd5);
    expect_snap("t3_rise", 0, 0, 2'd2, 1, 0, 2'b01, 2'b00, 8'd5, 8'd0);
    tick();
    launch_q.push_back(1'b1);
    expect_snap("t3_released", 0, 1, 2'd1, 1, 1, 2'b01, 2'b01, 8'd11, 8'd0);
    tick();
    expect_snap("t3_launch", 1, 1, 2'd1, 1, 1, 2'b11, 2'b01, 8'd11, 8'd5);
    tick();

    // T4: release of bank1 coincident with write completion on bank0
    drive(0, 0, 1, 8'd11, 1, 8'd5);
    expect_snap("t4_low", 0, 1, 2'd1, 1, 1, 2'b11, 2'b01, 8'd11, 8'd5);
    tick();
    drive(1, 1, 1, 8'd11, 1, 8'd5);
    expect_snap("t4_coinc", 0, 1, 2'd1, 1, 1, 2'b11, 2'b01, 8'd11, 8'd5);
    tick();
    drive(0, 1, 1, 8'd20, 1, 8'd4);
    launch_q.push_back(1'b0);
    expect_snap("t4_after", 0, 1, 2'd1, 1, 0, 2'b10, 2'b10, 8'd0, 8'd20);
    tick();
    expect_snap("t4_launch", 1, 1, 2'd1, 1, 0, 2'b11, 2'b10, 8'd4, 8'd20);
    tick();

    // T5: asynchronous reset mid-drain
    drive(0, 0, 1, 8'd20, 1, 8'd4);
    #2;
    reset = 1'b0;
    expect_snap("t5_async", 0, 1, 2'd0, 0, 0, 2'b01, 2'b01, 8'd20, 8'd0);
    tick();
    reset = 1'b1;
    drive(0, 1, 1, 8'd33, 0, 0);
    expect_snap("t5_post", 0, 1, 2'd0, 0, 0, 2'b01, 2'b01, 8'd33, 8'd0);
    tick();

    // T6: read with no draining bank is dropped
    drive(0, 1, 0, 0, 1, 8'd5);
    expect_snap("t6_rd_drop", 0, 1, 2'd0, 0, 0, 2'b00, 2'b00, 8'd0, 8'd0);
    tick();
    repeat (3) tick();

    checks++;
    if (launch_q.size() != 0) begin
      errors++;
      $display("FAIL launch_missing: got %0d pulses outstanding expected 0", launch_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
